data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the CPU's MEM-stage data port: it answers `mem_op`/`address`/`write_data` requests with a RAM region and a small memory-mapped I/O page. The I/O page holds a transmit FIFO, drained by an external consumer over valid/ready, and a free-running 16-bit timer. It replaces the plain data RAM at the CPU boundary. Read data is returned in the same cycle, so the CPU's MEM/WB register captures it at the next edge with no stall.

## Interface
- `RAM_DEPTH`, 256: RAM words; power of two, at most 65280 (`IO_BASE`).
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..8.
- `IO_BASE`, 16'hFF00: first address of the I/O page; the page spans `IO_BASE`..16'hFFFF.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `mem_op`  in  2  request type: 2'b00 none, 2'b01 read, 2'b10 write, 2'b11 reserved (treated as none).
- `address`  in  16  word address.
- `write_data`  in  16  write payload.
- `read_data`  out  16  combinational read result.
- `tx_data`  out  16  head of the TX FIFO.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head this cycle.

## Operation
- **Decode**
  - `address < IO_BASE`: RAM access at `address mod RAM_DEPTH`, using the low log2(`RAM_DEPTH`) bits; higher addresses alias.
  - Otherwise: I/O access at offset `address - IO_BASE`.
- **Read**
  - `read_data` is driven combinationally from the current `address` when `mem_op == 2'b01`.
  - For any other `mem_op`, `read_data` = 16'h0000.
- **Write**
  - Takes effect at the rising edge while `mem_op == 2'b10`.
- **I/O map** (offsets):
  - 0x00 TX_DATA
    - Write: push `write_data` into the FIFO.
    - Read: 0.
  - 0x01 TX_STATUS (read only)
    - Bit 0: empty. Bit 1: full. Bit 2: overflow (sticky). Bits 7:4: occupancy count. Other bits 0.
    - A read clears overflow at that edge.
    - Writes are ignored.
  - 0x02 TIMER
    - Read: current count.
    - Write: load `write_data`.
  - 0x03 SCRATCH: plain read/write 16-bit register.
  - All other offsets: read 0, writes ignored.
- **TX FIFO**
  - Circular buffer with a read pointer, a write pointer and a count of width log2(`FIFO_DEPTH`)+1.
  - Pop: occurs when `tx_valid && tx_ready`.
  - Push: accepted when not full, or when a pop happens in the same cycle.
  - Rejected push: data is dropped, count is unchanged, and overflow is set.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `tx_data` = `mem[rd_ptr]`. It is held stable while `tx_valid && !tx_ready`.
- **Timer**
  - Increments by 1 every cycle and wraps 16'hFFFF -> 16'h0000.
  - A write loads the value exactly; a load takes priority over the increment in that cycle.
- **RAM**
  - Contents are not reset.
  - A write and a read cannot coincide, because `mem_op` encodes a single request.

## Timing
- **Reset** (`rst_n` low at an edge):
  - FIFO empty, pointers 0, count 0, so `tx_valid` = 0.
  - Overflow = 0, timer = 0, SCRATCH = 0.
  - `read_data` follows the combinational rule (0 unless reading).
- **Reset mid-operation:**
  - Reset wins over any same-edge write, push or pop.
  - Pending FIFO entries are discarded.
  - RAM is untouched.
- **Read latency:** 0 cycles, combinational.
  - TIMER reads return the pre-edge value.
  - TX_STATUS reads return pre-edge flags; the overflow clear becomes visible the next cycle.
- **Push latency:** a push at edge N gives `tx_valid` = 1 in cycle N+1 if the FIFO was empty.
- **Pop latency:** after a pop at edge N, the next entry appears on `tx_data` in cycle N+1.
- **Timer reads:** read of TIMER at cycle k after reset returns k; reset edge = cycle 0.

## Test plan
- **RAM round trip:** write 16'hBEEF to 0x0010, then read 0x0010 -> `read_data` = 16'hBEEF. A read of 0x0110 with `RAM_DEPTH`=256 also gives 16'hBEEF (alias).
- **FIFO fill and overflow:** with `tx_ready` = 0, push 1,2,3,4,5.
  - STATUS reads 16'h0042: full, count 4.
  - After the 5th push, STATUS = 16'h0046: overflow set.
  - A second STATUS read returns 16'h0042.
  - Then raise `tx_ready` -> `tx_data` sequence is 1,2,3,4, and `tx_valid` falls after 4.
- **Full with simultaneous pop:** FIFO full, `tx_ready` = 1, push 9 -> accepted, count stays 4, no overflow, and 9 emerges last.
- **Timer:** write 16'hFFFE to 0xFF02; reads on the next two cycles return 16'hFFFE then 16'hFFFF, and the following cycle reads 0.
- **Reset mid-stream:** 3 entries queued, `tx_ready` toggling, `rst_n` low for one edge -> `tx_valid` = 0, STATUS = 16'h0001, TIMER restarts at 0, and RAM data written before reset still reads back.
- **Idle and unmapped:** `mem_op` = 2'b00 or 2'b11 -> `read_data` = 0 and no state change. Write to 0xFF07 leaves all registers unchanged, and a read of 0xFF07 returns 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data port responder with RAM, TX FIFO, timer and scratch I/O page
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   mem_op     in   2'b01 read, 2'b10 write, 2'b00/2'b11 none
//   address    in   16-bit word address (>= IO_BASE selects the I/O page)
//   write_data in   16-bit write payload
//   read_data  out  combinational read result, 0 unless reading
//   tx_data    out  head of the TX FIFO
//   tx_valid   out  TX FIFO non-empty
//   tx_ready   in   consumer accepts the head this cycle
module data_mem_responder #(
  parameter int          RAM_DEPTH  = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_op,
  input  logic [15:0] address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  logic [15:0] r_ram [RAM_DEPTH];
  logic [15:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PW:0] r_count;
  logic r_ovf;
  logic [15:0] r_timer, r_scratch;
  logic w_rd, w_wr, w_is_io, w_full, w_empty, w_pop, w_push_req, w_push;
  logic [15:0] w_off, w_status, w_io_rdata;
  logic [AW-1:0] w_ram_idx;
  assign w_rd       = mem_op == 2'b01;
  assign w_wr       = mem_op == 2'b10;
  assign w_is_io    = address >= IO_BASE;
  assign w_off      = address - IO_BASE;
  assign w_ram_idx  = address[AW-1:0];
  assign w_full     = r_count == FULL_CNT;
  assign w_empty    = r_count == '0;
  assign w_pop      = tx_valid && tx_ready;
  assign w_push_req = w_wr && w_is_io && w_off == 16'h0000;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_status   = {8'h00, 4'(r_count), 1'b0, r_ovf, w_full, w_empty};
  assign w_io_rdata = (w_off == 16'h0001) ? w_status  :
                      (w_off == 16'h0002) ? r_timer   :
                      (w_off == 16'h0003) ? r_scratch : 16'h0000;
  assign tx_data    = r_fifo[r_rd_ptr];
  assign tx_valid   = !w_empty;
  always_comb begin
    read_data = 16'h0000;
    if (w_rd) read_data = w_is_io ? w_io_rdata : r_ram[w_ram_idx];
  end
  // RAM and FIFO storage are not reset; reset only blocks a same-edge write
  always_ff @(posedge clk) begin
    if (rst_n && w_wr && !w_is_io) r_ram[w_ram_idx] <= write_data;
    if (rst_n && w_push) r_fifo[r_wr_ptr] <= write_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_timer   <= 16'h0000;
      r_scratch <= 16'h0000;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // reject and status read are both single requests, so they never collide
      if (w_push_req && !w_push) r_ovf <= 1'b1;
      else if (w_rd && w_is_io && w_off == 16'h0001) r_ovf <= 1'b0;
      r_timer <= (w_wr && w_is_io && w_off == 16'h0002) ? write_data : r_timer + 16'h0001;
      if (w_wr && w_is_io && w_off == 16'h0003) r_scratch <= write_data;
    end
  end
endmodule
